mult32x32_ctrl: RTL and testbench

Sequencing controller for the 32x32 multiplier arithmetic unit. It accepts a multiply request (start/busy handshake), latches both operands, and drives the arithmetic unit's half-word selects, shift select and product-register controls through the four 16x16 partial products. It then captures the 64-bit product into a result register and pulses done. It sits directly upstream of the arithmetic unit, which consumes its control outputs, and between that unit and the requesting logic.

---
 rtl/mult32x32_ctrl.sv | 132 +++++++++++++
 tb/tb_mult32x32_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl
//   Sequencing controller for the 32x32 multiplier arithmetic unit. Accepts a
//   request (start/busy), latches the operands, steps the arithmetic unit
//   through the four 16x16 partial products, then captures the 64-bit product
//   into result and pulses done.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start, a_in, b_in request and operands (sampled only in IDLE)
//   busy, done        handshake status; done is a one-cycle pulse
//   result            last completed product
//   op_a, op_b        latched operands to the arithmetic unit
//   a_sel, b_sel      half-word selects (0 = low, 1 = high)
//   shift_sel         partial-product shift (00 <<0, 01 <<16, 10 <<32)
//   upd_prod          accumulate partial product at next edge
//   clr_prod          clear the product register
//   product           arithmetic unit's product register
module mult32x32_ctrl #(
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        a_sel,
   output logic        b_sel,
   output logic [1:0]  shift_sel,
   output logic        upd_prod,
   output logic        clr_prod,
   input  logic [63:0] product
);

   // PPk is encoded as k+1 so the partial-product index maps directly.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PP0  = 3'd1,
      S_PP1  = 3'd2,
      S_PP2  = 3'd3,
      S_PP3  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t state, state_nxt;

   // First PP state with index >= from that must be visited, else DONE.
   // For PPk the a half-word is k[1] and the b half-word is k[0].
   function automatic state_t first_pp(input int from,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      state_t      r;
      logic [15:0] ah, bh;
      r = S_DONE;
      for (int k = 3; k >= 0; k--) begin
         ah = k[1] ? a[31:16] : a[15:0];
         bh = k[0] ? b[31:16] : b[15:0];
         if (k >= from && (!SKIP_ZERO || (ah != 16'd0 && bh != 16'd0)))
            r = state_t'(3'(k + 1));
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if (state == S_IDLE && start) begin
            op_a <= a_in;
            op_b <= b_in;
         end
         if (state == S_DONE) begin
            result <= product;
            done   <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      shift_sel = 2'b00;
      upd_prod  = 1'b0;
      clr_prod  = 1'b0;
      case (state)
         S_IDLE: begin
            busy     = 1'b0;
            clr_prod = 1'b1;
            // Leaving IDLE must decode the incoming operands; op_a/op_b
            // only take them at this same edge.
            if (start) state_nxt = first_pp(0, a_in, b_in);
         end
         S_PP0: begin
            upd_prod  = 1'b1;
            state_nxt = first_pp(1, op_a, op_b);
         end
         S_PP1: begin
            b_sel     = 1'b1;
            shift_sel = 2'b01;
            upd_prod  = 1'b1;
            state_nxt = first_pp(2, op_a, op_b);
         end
         S_PP2: begin
            a_sel     = 1'b1;
            shift_sel = 2'b01;
            upd_prod  = 1'b1;
            state_nxt = first_pp(3, op_a, op_b);
         end
         S_PP3: begin
            a_sel     = 1'b1;
            b_sel     = 1'b1;
            shift_sel = 2'b10;
            upd_prod  = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Testbench for mult32x32_ctrl: one instance with SKIP_ZERO=0 and one with
// SKIP_ZERO=1, each driving a small behavioural arithmetic unit.
module tb_mult32x32_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          failures = 0;

   logic        start0 = 1'b0, start1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        busy0, done0, asel0, bsel0, upd0, clr0;
   logic        busy1, done1, asel1, bsel1, upd1, clr1;
   logic [1:0]  sh0, sh1;
   logic [31:0] opa0, opb0, opa1, opb1;
   logic [63:0] res0, res1, prod0, prod1;

   always #5 clk = ~clk;

   mult32x32_ctrl #(.SKIP_ZERO(1'b0)) u0 (
      .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0),
      .busy(busy0), .done(done0), .result(res0), .op_a(opa0), .op_b(opb0),
      .a_sel(asel0), .b_sel(bsel0), .shift_sel(sh0), .upd_prod(upd0),
      .clr_prod(clr0), .product(prod0));

   mult32x32_ctrl #(.SKIP_ZERO(1'b1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
      .busy(busy1), .done(done1), .result(res1), .op_a(opa1), .op_b(opb1),
      .a_sel(asel1), .b_sel(bsel1), .shift_sel(sh1), .upd_prod(upd1),
      .clr_prod(clr1), .product(prod1));

   // Arithmetic unit models
   logic [15:0] ah0, bh0, ah1, bh1;
   logic [63:0] pp0, pp1;
   assign ah0 = asel0 ? opa0[31:16] : opa0[15:0];
   assign bh0 = bsel0 ? opb0[31:16] : opb0[15:0];
   assign ah1 = asel1 ? opa1[31:16] : opa1[15:0];
   assign bh1 = bsel1 ? opb1[31:16] : opb1[15:0];
   assign pp0 = ({48'd0, ah0} * {48'd0, bh0}) << {sh0, 4'b0};
   assign pp1 = ({48'd0, ah1} * {48'd0, bh1}) << {sh1, 4'b0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod0 <= '0;
         prod1 <= '0;
      end else begin
         if (clr0) prod0 <= '0; else if (upd0) prod0 <= prod0 + pp0;
         if (clr1) prod1 <= '0; else if (upd1) prod1 <= prod1 + pp1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and clears the operand inputs right after E0.
   // lat = edges after E0 until done is seen (-1 on timeout).
   task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output int bcnt);
      lat  = -1;
      bcnt = 0;
      res  = '0;
      if (sel) begin start1 = 1'b1; a1 = a; b1 = b; end
      else     begin start0 = 1'b1; a0 = a; b0 = b; end
      tick();
      start0 = 1'b0; start1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      for (int i = 1; i <= 20; i++) begin
         if (sel ? busy1 : busy0) bcnt++;
         tick();
         if (sel ? done1 : done0) begin
            lat = i;
            res = sel ? res1 : res0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if ({busy0, done0, clr0, busy1, done1, clr1} !== 6'b001_001) begin
         failures++;
         $display("FAIL reset_ctl got=%b want=001001", {busy0, done0, clr0, busy1, done1, clr1});
      end
      checks++;
      if ({res0, opa0, opb0} !== 128'd0) begin
         failures++;
         $display("FAIL reset_regs res=%h opa=%h opb=%h want 0", res0, opa0, opb0);
      end
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_walk();
      logic [5:0] exp_ctl [4];
      int busy_cnt;
      exp_ctl[0] = 6'b00_00_1_0;
      exp_ctl[1] = 6'b01_01_1_0;
      exp_ctl[2] = 6'b10_01_1_0;
      exp_ctl[3] = 6'b11_10_1_0;
      start0 = 1'b1; a0 = 32'h3; b0 = 32'h5;
      tick();
      start0 = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({asel0, bsel0, sh0, upd0, clr0} !== exp_ctl[k]) begin
            failures++;
            $display("FAIL walk_pp%0d ctl=%b want=%b", k, {asel0, bsel0, sh0, upd0, clr0}, exp_ctl[k]);
         end
         if (busy0) busy_cnt++;
         tick();
      end
      checks++;
      if ({busy0, done0, asel0, bsel0, sh0, upd0, clr0} !== 8'b10_000000) begin
         failures++;
         $display("FAIL walk_done_state got=%b want=10000000", {busy0, done0, asel0, bsel0, sh0, upd0, clr0});
      end
      if (busy0) busy_cnt++;
      tick();
      checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || res0 !== 64'hF || busy_cnt != 5) begin
         failures++;
         $display("FAIL walk_result done=%b busy=%b res=%h busy_cycles=%0d want 1 0 f 5",
                  done0, busy0, res0, busy_cnt);
      end
      tick();
      checks++;
      if (done0 !== 1'b0 || res0 !== 64'hF) begin
         failures++;
         $display("FAIL walk_hold done=%b res=%h want 0 f", done0, res0);
      end
   endtask

   task automatic test_max();
      int lat, bc;
      logic [63:0] r;
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, bc);
      checks++;
      if (lat != 5 || r !== 64'hFFFF_FFFE_0000_0001) begin
         failures++;
         $display("FAIL max lat=%0d res=%h want 5 fffffffe00000001", lat, r);
      end
      tick();
   endtask

   task automatic test_skip_zero();
      int lat, bc;
      logic [63:0] r;
      do_op(1'b1, 32'h0001_0000, 32'h0000_0002, lat, r, bc);
      checks++;
      if (lat != 2 || r !== 64'h0000_0000_0002_0000 || bc != 2) begin
         failures++;
         $display("FAIL skip_pp2 lat=%0d res=%h busy=%0d want 2 20000 2", lat, r, bc);
      end
      tick();
      do_op(1'b1, 32'h0, 32'h5, lat, r, bc);
      checks++;
      if (lat != 1 || r !== 64'h0) begin
         failures++;
         $display("FAIL skip_none lat=%0d res=%h want 1 0", lat, r);
      end
      tick();
      do_op(1'b1, 32'h0001_0001, 32'h0001_0000, lat, r, bc);
      checks++;
      if (lat != 3 || r !== 64'h0000_0001_0001_0000) begin
         failures++;
         $display("FAIL skip_pp13 lat=%0d res=%h want 3 100010000", lat, r);
      end
      tick();
      do_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, lat, r, bc);
      checks++;
      if (lat != 5 || r !== 64'h0B00_EA4E_242D_2080) begin
         failures++;
         $display("FAIL skip_all lat=%0d res=%h want 5 0b00ea4e242d2080", lat, r);
      end
      tick();
   endtask

   task automatic test_start_held();
      int lat;
      start0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h9ABC_DEF0;
      tick();
      a0 = 32'd2; b0 = 32'd3;
      tick();
      checks++;
      if (opa0 !== 32'h1234_5678 || opb0 !== 32'h9ABC_DEF0) begin
         failures++;
         $display("FAIL held_relatch opa=%h opb=%h want 12345678 9abcdef0", opa0, opb0);
      end
      lat = -1;
      for (int i = 2; i <= 20; i++) begin
         tick();
         if (done0) begin lat = i; break; end
      end
      checks++;
      if (lat != 5 || res0 !== 64'h0B00_EA4E_242D_2080) begin
         failures++;
         $display("FAIL held_first lat=%0d res=%h want 5 0b00ea4e242d2080", lat, res0);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) start0 = 1'b0;
         if (done0) begin lat = i; break; end
      end
      checks++;
      if (lat != 6 || res0 !== 64'd6) begin
         failures++;
         $display("FAIL held_second lat=%0d res=%h want 6 6", lat, res0);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, bc, seen;
      logic [63:0] r;
      start0 = 1'b1; a0 = 32'h9; b0 = 32'h9;
      tick();
      start0 = 1'b0;
      tick();
      tick();
      checks++;
      if ({asel0, bsel0, sh0} !== 4'b10_01) begin
         failures++;
         $display("FAIL mid_in_pp2 ctl=%b want=1001", {asel0, bsel0, sh0});
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== 64'd0 || clr0 !== 1'b1) begin
         failures++;
         $display("FAIL mid_async busy=%b done=%b res=%h clr=%b want 0 0 0 1", busy0, done0, res0, clr0);
      end
      tick();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done0 || busy0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL mid_no_done activity_cycles=%0d want 0", seen);
      end
      do_op(1'b0, 32'd2, 32'd3, lat, r, bc);
      checks++;
      if (lat != 5 || r !== 64'd6) begin
         failures++;
         $display("FAIL mid_recover lat=%0d res=%h want 5 6", lat, r);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat, bc, hold_bad;
      logic [63:0] r;
      do_op(1'b0, 32'd2, 32'd3, lat, r, bc);
      checks++;
      if (lat != 5 || r !== 64'd6) begin
         failures++;
         $display("FAIL b2b_first lat=%0d res=%h want 5 6", lat, r);
      end
      start0 = 1'b1; a0 = 32'd7; b0 = 32'd11;
      tick();
      start0 = 1'b0;
      lat = -1;
      hold_bad = 0;
      for (int i = 1; i <= 20; i++) begin
         if (res0 !== 64'd6) hold_bad++;
         tick();
         if (done0) begin lat = i + 1; break; end
      end
      checks++;
      if (lat != 6 || res0 !== 64'h4D || hold_bad != 0) begin
         failures++;
         $display("FAIL b2b_second period=%0d res=%h hold_errs=%0d want 6 4d 0", lat, res0, hold_bad);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_walk();
      test_max();
      test_skip_zero();
      test_start_held();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
